// File: rtl/pll_step_sequencer.sv
// Per-time-step controller for the PLL control datapath: releases the user reset,
// issues one sta per step, waits for pll_done, then strobes the commit to the state registers.
`timescale 1ns/1ps
module pll_step_sequencer #(
  parameter int unsigned STEP_CYCLES = 500,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 256,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ext_mode,
  input  logic             step_ext,
  input  logic             init_req,
  input  logic             pll_done,
  output logic             sta,
  output logic             rst_user,
  output logic             control_valuation_sig,
  output logic             busy,
  output logic             overrun,
  output logic             fault,
  output logic [CNT_W-1:0] step_count,
  output logic [15:0]      latency,
  output logic [2:0]       state_dbg
);

  localparam int TMR_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(STEP_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [15:0]       TMO_VAL   = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_WAIT_TRIG = 3'd1,
    S_START     = 3'd2,
    S_COMPUTE   = 3'd3,
    S_COMMIT    = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic [TMR_W-1:0]  timer;
  logic [15:0]       lat_cnt, lat_inc;
  logic              trig;

  // Datapath handshake: sta is a one-cycle request with no backpressure; the datapath
  // answers with a one-cycle pll_done, which is accepted only while in COMPUTE.
  assign sta                   = (state == S_START);
  assign control_valuation_sig = (state == S_COMMIT);
  assign rst_user              = (state == S_INIT);
  assign busy                  = (state == S_START) || (state == S_COMPUTE) || (state == S_COMMIT);
  assign state_dbg             = state;

  assign trig    = ext_mode ? (step_ext & enable) : (timer == TMR_LAST);
  assign lat_inc = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

  always_comb begin
    state_nxt = state;
    if (init_req) begin
      state_nxt = S_INIT;
    end else begin
      case (state)
        S_INIT:      if (init_cnt == INIT_LAST) state_nxt = S_WAIT_TRIG;
        S_WAIT_TRIG: if (trig) state_nxt = S_START;
        S_START:     state_nxt = S_COMPUTE;
        S_COMPUTE: begin
          if (pll_done)                state_nxt = S_COMMIT;
          else if (lat_inc == TMO_VAL) state_nxt = S_HALT;
        end
        S_COMMIT:    state_nxt = S_WAIT_TRIG;
        S_HALT:      state_nxt = S_HALT;
        default:     state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      timer      <= '0;
      lat_cnt    <= '0;
      latency    <= '0;
      step_count <= '0;
      overrun    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (init_req) begin
        init_cnt   <= '0;
        timer      <= '0;
        lat_cnt    <= '0;
        step_count <= '0;
        overrun    <= 1'b0;
        fault      <= 1'b0;
      end else begin
        init_cnt <= (state == S_INIT) ? init_cnt + INIT_W'(1) : '0;
        // The timer free-runs across steps so the step period stays exactly STEP_CYCLES.
        if ((state == S_INIT) || (state == S_HALT) || !enable || (timer == TMR_LAST))
          timer <= '0;
        else
          timer <= timer + TMR_W'(1);
        if (busy && trig)
          overrun <= 1'b1;
        case (state)
          S_START:   lat_cnt <= '0;
          S_COMPUTE: begin
            lat_cnt <= lat_inc;
            if (pll_done)                latency <= lat_inc;
            else if (lat_inc == TMO_VAL) fault   <= 1'b1;
          end
          S_COMMIT:  step_count <= step_count + CNT_W'(1);
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_step_sequencer.sv
// Randomized bench for pll_step_sequencer: a step-level behavioural model predicts every
// output each cycle, plus literal expectations at the directed scenario points.
`timescale 1ns/1ps
module tb_pll_step_sequencer;

  localparam int STEP  = 200;
  localparam int INITC = 4;
  localparam int TMO   = 256;
  localparam int CW    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic enable = 1'b0, ext_mode = 1'b0, step_ext = 1'b0, init_req = 1'b0, pll_done = 1'b0;
  logic sta, rst_user, cvs, busy, overrun, fault;
  logic [CW-1:0] step_count;
  logic [15:0]   latency;
  logic [2:0]    state_dbg;

  pll_step_sequencer #(
    .STEP_CYCLES(STEP), .INIT_CYCLES(INITC), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ext_mode(ext_mode), .step_ext(step_ext),
    .init_req(init_req), .pll_done(pll_done), .sta(sta), .rst_user(rst_user),
    .control_valuation_sig(cvs), .busy(busy), .overrun(overrun), .fault(fault),
    .step_count(step_count), .latency(latency), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ph  = 0;

  // stimulus knobs
  int k_ext = 0, k_en = 1, k_en_flip = 0, k_ext_period = 0, k_ext_prob = 0;
  int k_lat_lo = 128, k_lat_hi = 128, k_noise = 0, k_init_pm = 0, k_init_at_done = 0;
  bit force_ext = 0, force_init = 0;
  int done_at = -1;

  // behavioural model: what each output must be in the current cycle
  int m_init_left, m_age, m_count, m_lat, m_timer;
  bit m_halted, m_sta, m_commit, m_ovr, m_flt;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_init_left = INITC; m_age = 0; m_count = 0; m_lat = 0; m_timer = 0;
    m_halted = 0; m_sta = 0; m_commit = 0; m_ovr = 0; m_flt = 0;
    exp_q.delete();
  endtask

  task automatic model_update();
    bit trig, in_step;
    int nt;
    trig    = ext_mode ? (step_ext && enable) : (m_timer == STEP - 1);
    in_step = m_sta || (m_age > 0) || m_commit;
    if (init_req) begin
      m_init_left = INITC; m_halted = 0; m_sta = 0; m_age = 0; m_commit = 0;
      m_count = 0; m_ovr = 0; m_flt = 0; m_timer = 0;
    end else begin
      nt = (m_init_left > 0 || m_halted || !enable) ? 0 : (m_timer + 1) % STEP;
      if (in_step && trig) m_ovr = 1;
      if (m_init_left > 0) m_init_left--;
      else if (m_halted) m_halted = 1;
      else if (m_sta) begin
        m_sta = 0; m_age = 1;
      end else if (m_age > 0) begin
        if (pll_done) begin
          m_lat = (m_age > 65535) ? 65535 : m_age;
          m_age = 0; m_commit = 1;
          exp_q.push_back(16'(m_lat));
        end else if (m_age == TMO) begin
          m_flt = 1; m_halted = 1; m_age = 0;
        end else m_age++;
      end else if (m_commit) begin
        m_commit = 0; m_count = (m_count + 1) % (1 << CW);
      end else if (trig) m_sta = 1;
      m_timer = nt;
    end
  endtask

  task automatic compare_all();
    check("sta", 32'(sta), 32'(m_sta));
    check("commit", 32'(cvs), 32'(m_commit));
    check("rst_user", 32'(rst_user), 32'(m_init_left > 0));
    check("busy", 32'(busy), 32'(m_sta || m_age > 0 || m_commit));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("fault", 32'(fault), 32'(m_flt));
    check("step_count", 32'(step_count), 32'(m_count));
    check("latency", 32'(latency), 32'(m_lat));
    if (cvs === 1'b1) begin
      if (exp_q.size() == 0) check("commit_queue_empty", 32'(exp_q.size()), 32'd1);
      else check("commit_latency", 32'(latency), 32'(exp_q.pop_front()));
    end
  endtask

  // driver: inputs change at the negedge, datapath responds after a random latency
  task automatic drive();
    bit sched;
    if (m_sta) done_at = (k_lat_hi == 0) ? -1 : cyc + int'($urandom_range(k_lat_hi, k_lat_lo));
    sched    = (cyc == done_at);
    pll_done = sched || ($urandom_range(0, 99) < k_noise);
    step_ext = force_ext || (k_ext_period > 0 && (ph % k_ext_period) == 0) ||
               ($urandom_range(0, 99) < k_ext_prob);
    init_req = force_init || (k_init_at_done != 0 && sched) || ($urandom_range(0, 999) < k_init_pm);
    if ($urandom_range(0, 99) < k_en_flip) k_en = (k_en == 0) ? 1 : 0;
    enable   = (k_en != 0);
    ext_mode = (k_ext != 0);
    force_ext = 0; force_init = 0;
    cyc++; ph++;
  endtask

  // entered and left at a negedge
  task automatic tick();
    compare_all();
    drive();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_rst_user", 32'(rst_user), 32'd1);
    check("reset_sta", 32'(sta), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_step_count", 32'(step_count), 32'd0);
    rst = 1'b1;
    k_en = 1;

    // internal timer, fixed 128-cycle datapath
    run(3);
    check("init_held_c3", 32'(rst_user), 32'd1);
    tick();
    check("init_released_c4", 32'(rst_user), 32'd0);
    run(200);
    check("first_sta_c204", 32'(sta), 32'd1);
    run(556);
    check("int_count3", 32'(step_count), 32'd3);
    check("int_latency128", 32'(latency), 32'd128);
    check("int_no_overrun", 32'(overrun), 32'd0);

    // external ticks 50 cycles apart with 128-cycle latency
    force_init = 1; k_ext = 1;
    tick();
    check("ext_init_count0", 32'(step_count), 32'd0);
    run(9);
    ph = 0; k_ext_period = 50;
    run(135);
    check("ext_one_commit", 32'(step_count), 32'd1);
    check("ext_overrun", 32'(overrun), 32'd1);
    run(155);
    check("ext_two_commits", 32'(step_count), 32'd2);
    k_ext_period = 0;

    // timeout: datapath never answers
    force_init = 1; k_lat_lo = 0; k_lat_hi = 0;
    run(10);
    force_ext = 1;
    tick();
    check("to_sta", 32'(sta), 32'd1);
    run(256);
    check("to_fault_not_yet", 32'(fault), 32'd0);
    tick();
    check("to_fault_set", 32'(fault), 32'd1);
    check("to_halt_not_busy", 32'(busy), 32'd0);
    run(12);
    force_ext = 1;
    tick();
    check("halt_no_sta", 32'(sta), 32'd0);
    check("halt_no_overrun", 32'(overrun), 32'd0);
    run(19);
    force_init = 1;
    tick();
    check("to_fault_cleared", 32'(fault), 32'd0);
    k_lat_lo = 128; k_lat_hi = 128;
    run(9);
    force_ext = 1;
    run(140);
    check("resume_count1", 32'(step_count), 32'd1);
    check("resume_latency", 32'(latency), 32'd128);

    // init_req together with pll_done mid-compute
    k_init_at_done = 1; force_ext = 1;
    run(130);
    check("abort_no_commit", 32'(cvs), 32'd0);
    check("abort_count0", 32'(step_count), 32'd0);
    check("abort_rst_user", 32'(rst_user), 32'd1);
    k_init_at_done = 0;
    run(3);
    check("abort_init_held", 32'(rst_user), 32'd1);
    tick();
    check("abort_init_done", 32'(rst_user), 32'd0);

    // count wrap: 17 steps with CNT_W=4
    k_ext = 0; k_lat_lo = 1; k_lat_hi = 80; force_init = 1;
    run(3500);
    check("wrap_count1", 32'(step_count), 32'd1);

    // randomized segments
    for (int s = 0; s < 15; s++) begin
      k_ext        = $urandom_range(0, 1);
      k_ext_prob   = (k_ext != 0) ? $urandom_range(0, 3) : 0;
      k_ext_period = (k_ext != 0 && $urandom_range(0, 1) == 1) ? $urandom_range(60, 250) : 0;
      k_lat_lo     = $urandom_range(1, 100);
      k_lat_hi     = k_lat_lo + $urandom_range(0, 200);
      k_noise      = $urandom_range(0, 2);
      k_init_pm    = $urandom_range(0, 4);
      k_en_flip    = $urandom_range(0, 2);
      run(200);
    end

    // asynchronous reset mid-step
    k_ext = 0; k_en = 1; k_en_flip = 0; k_ext_prob = 0; k_ext_period = 0;
    k_lat_lo = 100; k_lat_hi = 100; k_noise = 0; k_init_pm = 0; force_init = 1;
    reached = 0;
    for (int i = 0; i < 600 && !reached; i++) begin
      tick();
      reached = (m_age > 10);
    end
    check("reached_compute", 32'(reached), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_user", 32'(rst_user), 32'd1);
    check("async_sta", 32'(sta), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_commit", 32'(cvs), 32'd0);
    check("async_overrun", 32'(overrun), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    check("async_count", 32'(step_count), 32'd0);
    check("async_latency", 32'(latency), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_step_sequencer.md
Name: pll_step_sequencer

Overview:
Per-time-step controller for the three-phase PLL control datapath. It releases the datapath's user reset after start-up and generates one start pulse per simulation time step, from an internal step timer or an external tick. It then waits for the datapath's done pulse and issues a one-cycle commit strobe so the PI integrators and sin/cos partition registers latch the new state. It also counts steps and flags overruns and timeouts.

Parameters:
STEP_CYCLES, 500, clock cycles per time step in internal-timer mode (minimum LATENCY+4)
INIT_CYCLES, 4, cycles rst_user is held asserted in INIT
TIMEOUT, 256, max cycles from sta to pll_done before a fault is raised
CNT_W, 32, width of step_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
enable  in  1  1 = accept step triggers
ext_mode  in  1  1 = trigger from step_ext; 0 = internal step timer
step_ext  in  1  external step tick, one-cycle pulse
init_req  in  1  one-cycle request to re-initialise the datapath
pll_done  in  1  datapath done pulse
sta  out  1  datapath start pulse
rst_user  out  1  datapath user-state reset, active-high
control_valuation_sig  out  1  commit strobe to the PI and partition registers
busy  out  1  step in progress (START, COMPUTE or COMMIT)
overrun  out  1  sticky: a trigger arrived while busy
fault  out  1  sticky: pll_done timeout
step_count  out  CNT_W  number of committed steps
latency  out  16  sta-to-pll_done cycle count of the last completed step

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst=0: FSM=INIT with its counter at 0, rst_user=1, and sta, control_valuation_sig, busy, overrun, fault=0. step_count=0, latency=0, step timer=0.
- FSM states: INIT, WAIT_TRIG, START, COMPUTE, COMMIT, HALT.
- INIT: rst_user=1 for exactly INIT_CYCLES cycles after entry, then WAIT_TRIG with rst_user=0.
- Trigger in ext_mode=1: trig = step_ext & enable.
- Trigger in ext_mode=0: the step timer counts 0..STEP_CYCLES-1 while enable=1 and wraps. trig = (timer==STEP_CYCLES-1). The timer is held at 0 while enable=0 or in INIT/HALT.
- WAIT_TRIG: on trig, go to START.
- START: sta=1 for exactly one cycle. The latency counter is cleared. Go to COMPUTE.
- COMPUTE: the latency counter increments every cycle and saturates at 0xFFFF.
  - On pll_done=1: latency <= counter value, go to COMMIT.
  - If the counter reaches TIMEOUT without pll_done: fault <= 1, go to HALT.
- COMMIT: control_valuation_sig=1 for one cycle. step_count increments, wrapping modulo 2^CNT_W. Go to WAIT_TRIG.
- HALT: no sta or commit output. Triggers are ignored. The only exit is init_req.
- pll_done outside COMPUTE is ignored and has no effect on any output or state.
- A trig in START, COMPUTE or COMMIT sets overrun=1 (sticky) and is dropped; no queued step.
- enable falling mid-step: the current step runs to COMMIT, and WAIT_TRIG then waits.
- init_req from any state:
  - FSM goes to INIT on the next edge.
  - step_count, overrun and fault are cleared.
  - The latency counter and step timer are cleared.
  - Any in-flight step is abandoned with no commit strobe.
  - init_req has priority over a simultaneous trig, pll_done or timeout.
- Minimum step period: 3 cycles plus datapath latency. sta and control_valuation_sig are never high in the same cycle.
- Outputs are registered. sta and control_valuation_sig are decoded from registered state, with no input-to-output combinational path.

Test Plan:
- Reset and init: release rst with INIT_CYCLES=4 -> rst_user=1 for 4 cycles after release then 0, and no sta before the first trigger.
- Internal timer: STEP_CYCLES=200, datapath model returns pll_done 128 cycles after sta -> sta every 200 cycles, commit one cycle after pll_done, latency=128, step_count=1,2,3.
- External mode, overrun: ext_mode=1, step_ext pulses 50 cycles apart with 128-cycle latency -> the second pulse is dropped, overrun=1, only one commit until the next accepted pulse.
- Timeout: pll_done never returned, TIMEOUT=256 -> fault=1 at the 256th COMPUTE cycle, HALT, no further sta. init_req -> fault=0, INIT, stepping resumes.
- init_req mid-COMPUTE together with pll_done -> no control_valuation_sig, step_count=0, rst_user asserted 4 cycles.
- Wrap: CNT_W=4, 17 steps -> step_count=1. Async rst asserted mid-step -> all outputs reach reset values without a clock edge.
